// File: rtl/rename_pkg.sv
// ---------------------------------------------------------------------------
// rename_pkg
//   Sizing shared by the rename stage: free list, areg table and ROB.
//   PREG_WIDTH  physical tag width
//   NUM_PREG    total physical registers
//   NUM_AREG    architectural registers (tags 0..NUM_AREG-1 mapped at reset)
//   FREE_DEPTH  free-list capacity
//   FREE_CNT_W  width of a 0..FREE_DEPTH counter
// ---------------------------------------------------------------------------
package rename_pkg;

   localparam int PREG_WIDTH = 6;
   localparam int NUM_PREG   = 64;
   localparam int NUM_AREG   = 32;
   localparam int FREE_DEPTH = NUM_PREG - NUM_AREG;
   localparam int FREE_CNT_W = $clog2(FREE_DEPTH + 1);

   typedef logic [PREG_WIDTH-1:0] preg_tag_t;

endpackage : rename_pkg

// File: rtl/free_list_ram.sv
// ---------------------------------------------------------------------------
// free_list_ram
//   DEPTH x WIDTH storage for the physical-register free list.
//   Contents come out of reset holding INIT_BASE+i in entry i, i.e. the
//   physical tags that are not mapped by the architectural table.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   we           write enable (synchronous)
//   waddr/wdata  write address / data
//   raddr        read address
//   rdata        read data (combinational)
// ---------------------------------------------------------------------------
module free_list_ram #(
   parameter int DEPTH     = 32,
   parameter int WIDTH     = 6,
   parameter int INIT_BASE = 32,
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(INIT_BASE + i);
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : free_list_ram

// File: rtl/preg_free_list.sv
// ---------------------------------------------------------------------------
// preg_free_list
//   Physical-register free list for rename. Circular FIFO of unmapped
//   physical tags: grants one tag per cycle to rename, reclaims one tag per
//   cycle from retire.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   alloc_req       rename wants a tag this cycle
//   alloc_gnt       grant; alloc_tag is consumed this cycle
//   alloc_tag       tag at head of list (or bypassed release tag)
//   release_valid   retire returns release_tag (tag 0 is ignored)
//   release_tag     tag being freed
//   free_count      number of free tags held
//   empty / full    free_count == 0 / == DEPTH
//   overflow_err    sticky: a release was dropped on a full list
// Build option:
//   FREE_LIST_BYPASS_EN  when empty, a same-cycle release is handed straight
//                        to a pending request instead of being stored.
// ---------------------------------------------------------------------------
module preg_free_list
   import rename_pkg::*;
#(
   parameter int PREG_WIDTH = rename_pkg::PREG_WIDTH,
   parameter int NUM_PREG   = rename_pkg::NUM_PREG,
   parameter int NUM_AREG   = rename_pkg::NUM_AREG,
   localparam int DEPTH     = NUM_PREG - NUM_AREG,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alloc_req,
   output logic                  alloc_gnt,
   output logic [PREG_WIDTH-1:0] alloc_tag,
   input  logic                  release_valid,
   input  logic [PREG_WIDTH-1:0] release_tag,
   output logic [CW-1:0]         free_count,
   output logic                  empty,
   output logic                  full,
   output logic                  overflow_err
);

   logic [AW-1:0]         head, tail;
   logic [CW-1:0]         count;
   logic [PREG_WIDTH-1:0] head_tag;
   logic                  rel_ok;     // release that actually carries a tag
   logic                  pop;        // grant served from storage
   logic                  push;       // release written at tail
   logic                  drop;       // release lost to a full list
   logic                  byp;        // release handed straight to requester

   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty      = (count == '0);
   assign full       = (count == CW'(DEPTH));
   assign free_count = count;

   // x0 is never renamed, so a release of tag 0 carries nothing
   assign rel_ok = release_valid && (release_tag != '0);

`ifdef FREE_LIST_BYPASS_EN
   assign byp = empty && alloc_req && rel_ok;
`else
   assign byp = 1'b0;
`endif

   assign pop       = alloc_req && !empty;
   assign alloc_gnt = pop || byp;
   assign alloc_tag = byp ? release_tag : head_tag;

   // A grant on a full list frees the slot the release needs this cycle
   assign push = rel_ok && !byp && (!full || pop);
   assign drop = rel_ok && full && !pop;

   free_list_ram #(
      .DEPTH     (DEPTH),
      .WIDTH     (PREG_WIDTH),
      .INIT_BASE (NUM_AREG)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .waddr (tail),
      .wdata (release_tag),
      .raddr (head),
      .rdata (head_tag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head         <= '0;
         tail         <= '0;
         count        <= CW'(DEPTH);
         overflow_err <= 1'b0;
      end else begin
         if (pop)  head <= wrap_inc(head);
         if (push) tail <= wrap_inc(tail);
         if (pop && !push)      count <= count - CW'(1);
         else if (push && !pop) count <= count + CW'(1);
         if (drop) overflow_err <= 1'b1;
      end
   end

endmodule : preg_free_list

// File: tb/tb_preg_free_list.sv
// ---------------------------------------------------------------------------
// tb_preg_free_list
//   Directed stimulus for preg_free_list. Expected grant tags are queued by
//   the stimulus; a monitor pops one per observed grant and compares.
//   Counts/flags are checked directly after each clock edge.
// ---------------------------------------------------------------------------
module tb_preg_free_list;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       alloc_req;
   logic       alloc_gnt;
   logic [5:0] alloc_tag;
   logic       release_valid;
   logic [5:0] release_tag;
   logic [5:0] free_count;
   logic       empty;
   logic       full;
   logic       overflow_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic [5:0] exp_q [$];

   always #5 clk = ~clk;

   preg_free_list dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alloc_req     (alloc_req),
      .alloc_gnt     (alloc_gnt),
      .alloc_tag     (alloc_tag),
      .release_valid (release_valid),
      .release_tag   (release_tag),
      .free_count    (free_count),
      .empty         (empty),
      .full          (full),
      .overflow_err  (overflow_err)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Grant monitor: every observed grant must match the oldest queued tag
   always @(negedge clk) begin
      if (rst_n === 1'b1 && alloc_gnt === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_grant: got tag %0d expected no grant", alloc_tag);
         end else begin
            chk("grant_tag", int'(alloc_tag), int'(exp_q[0]));
            exp_q.delete(0);
         end
      end
   end

   // One clock: drive inputs just after posedge, check grant mid-cycle,
   // check registered count after the edge.
   task automatic step(input logic req, input logic rv, input int tag,
                       input int exp_gnt, input int exp_cnt);
      alloc_req     = req;
      release_valid = rv;
      release_tag   = 6'(tag);
      @(negedge clk);
      #1;
      chk("alloc_gnt", int'(alloc_gnt), exp_gnt);
      @(posedge clk);
      #1;
      chk("free_count", int'(free_count), exp_cnt);
      alloc_req     = 1'b0;
      release_valid = 1'b0;
      release_tag   = '0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_free_count", int'(free_count), 32);
      chk("rst_full", int'(full), 1);
      chk("rst_empty", int'(empty), 0);
      chk("rst_alloc_gnt", int'(alloc_gnt), 0);
      chk("rst_overflow", int'(overflow_err), 0);
   endtask

   // Assert reset asynchronously (mid-cycle), check, then release it
   task automatic do_reset();
      alloc_req     = 1'b0;
      release_valid = 1'b0;
      release_tag   = '0;
      rst_n         = 1'b0;
      #1;
      chk_reset_vals();
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // Drain: 32..63 in order
      for (int i = 0; i < 32; i++) begin
         exp_q.push_back(6'(32 + i));
         step(1'b1, 1'b0, 0, 1, 31 - i);
      end
      chk("drained_empty", int'(empty), 1);
      step(1'b1, 1'b0, 0, 0, 0);

      // Refill 40, 35 and allocate them back
      step(1'b0, 1'b1, 40, 0, 1);
      step(1'b0, 1'b1, 35, 0, 2);
      exp_q.push_back(6'd40);
      step(1'b1, 1'b0, 0, 1, 1);
      exp_q.push_back(6'd35);
      step(1'b1, 1'b0, 0, 1, 0);

      // Tag 0 release while empty with a request: nothing happens
      step(1'b1, 1'b1, 0, 0, 0);

      // Empty + request + release in the same cycle
`ifdef FREE_LIST_BYPASS_EN
      exp_q.push_back(6'd45);
      step(1'b1, 1'b1, 45, 1, 0);
`else
      step(1'b1, 1'b1, 45, 0, 1);
      exp_q.push_back(6'd45);
      step(1'b1, 1'b0, 0, 1, 0);
`endif

      // Full list: tag 0 ignored, tag 50 dropped
      do_reset();
      step(1'b0, 1'b1, 0, 0, 32);
      chk("tag0_no_overflow", int'(overflow_err), 0);
      step(1'b0, 1'b1, 50, 0, 32);
      chk("drop_overflow", int'(overflow_err), 1);
      chk("drop_full", int'(full), 1);

      // Full list with grant: 32 granted, 50 accepted
      do_reset();
      exp_q.push_back(6'd32);
      step(1'b1, 1'b1, 50, 1, 32);
      chk("gnt_rel_no_overflow", int'(overflow_err), 0);

      // Set the sticky error, then run 10 grants and 3 releases
      step(1'b0, 1'b1, 51, 0, 32);
      chk("sticky_overflow", int'(overflow_err), 1);
      for (int i = 0; i < 10; i++) begin
         exp_q.push_back(6'(33 + i));
         step(1'b1, 1'b0, 0, 1, 31 - i);
      end
      step(1'b0, 1'b1, 5, 0, 23);
      step(1'b0, 1'b1, 6, 0, 24);
      step(1'b0, 1'b1, 7, 0, 25);
      chk("sticky_held", int'(overflow_err), 1);

      // Mid-stream async reset, then first grant must be 32
      do_reset();
      exp_q.push_back(6'd32);
      step(1'b1, 1'b0, 0, 1, 31);

      chk("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_preg_free_list

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list allocator for the rename stage. It holds every physical tag not currently mapped by the architectural tag table. It grants one free tag per cycle to the rename requester, whose tag becomes `rd_tag` on the register-file rename write. It reclaims one tag per cycle from retire, which is the `rd_old_tag` of the committing instruction.

## Interface
- PREG_WIDTH, 6, physical tag width
- NUM_PREG, 64, total physical registers
- NUM_AREG, 32, architectural registers; tags 0..NUM_AREG-1 are mapped at reset
- DEPTH, NUM_PREG-NUM_AREG, free-list capacity (derived; do not override)

- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_req  in  1  rename stage requests one tag this cycle
- alloc_gnt  out  1  request granted; `alloc_tag` is consumed this cycle
- alloc_tag  out  PREG_WIDTH  tag at the head of the list; only meaningful when `alloc_gnt`=1
- release_valid  in  1  retire returns a tag
- release_tag  in  PREG_WIDTH  tag being freed
- free_count  out  $clog2(DEPTH+1)  number of free tags held
- empty  out  1  free_count==0
- full  out  1  free_count==DEPTH
- overflow_err  out  1  sticky; a release was dropped because the list was full

## Operation
- Circular FIFO of DEPTH entries with head pointer, tail pointer and count; both pointers wrap modulo DEPTH.
- Reset (async, rst_n=0):
  - entry i = NUM_AREG+i;
  - head=0, tail=0, count=DEPTH;
  - full=1, empty=0, free_count=DEPTH, alloc_gnt=0, overflow_err=0.
- Allocation:
  - alloc_gnt = alloc_req & ~empty.
  - On grant, head advances by 1 and count decrements.
- Release:
  - release_valid with release_tag==0 is ignored, because x0 is never renamed.
  - Otherwise the tag is written at tail, tail advances and count increments.
  - Release while full (and no grant this cycle) drops the tag and sets overflow_err; overflow_err clears only on reset.
- Simultaneous grant and release:
  - Both take effect and count is unchanged.
  - When full, the grant frees a slot, so the release is accepted and overflow_err is not set.
- Release while empty, without bypass: the tag is stored, and alloc_gnt=0 this cycle.
- Tags outside 0..NUM_PREG-1 cannot occur because of the port width. Release of a tag already free is not detected.

## Timing
- `alloc_tag` and `alloc_gnt` are combinational from head, count and alloc_req, with zero-cycle latency.
- The head/tail/count update is visible the next cycle.
- A released tag is allocatable no earlier than the cycle after release, except on the bypass path.
- Reset asserted mid-operation discards all in-flight state immediately. The table owner must reset its tag mapping in the same cycle.

## Configuration
- `FREE_LIST_BYPASS_EN` defined:
  - When empty=1, alloc_req=1 and release_valid=1 with release_tag!=0, then alloc_gnt=1 and alloc_tag=release_tag in the same cycle.
  - Nothing is written and count stays 0.
- Undefined: no bypass; empty always blocks the grant.

## Structure
- Shared package `rename_pkg`:
  - PREG_WIDTH, NUM_PREG, NUM_AREG;
  - `preg_tag_t` typedef;
  - FREE_DEPTH constant.
- The areg file and the ROB share this package.
- One sub-module, `free_list_ram`:
  - DEPTH×PREG_WIDTH storage;
  - one synchronous write port, one combinational read port;
  - reset-initialised contents.
- Pointer, count, grant and bypass logic live in the top module.

## Test plan
- Reset, then alloc_req held for 32 cycles:
  - tags 32,33,…,63 granted in order;
  - empty=1 after the 32nd grant;
  - the 33rd cycle gives alloc_gnt=0.
- From empty, release tags 40 then 35, then request:
  - grants 40 then 35;
  - free_count goes 0→1→2→1→0.
- Reset (full), with release_valid=1, tag=50 and alloc_req=0:
  - tag dropped, overflow_err=1, free_count stays 32.
- Same stimulus with alloc_req=1: grant 32 and accept 50, overflow_err=0.
- Release tag 0 → ignored, free_count unchanged.
- Empty with alloc_req=1 and release 45 in the same cycle:
  - with `FREE_LIST_BYPASS_EN`, alloc_gnt=1 and alloc_tag=45, count stays 0;
  - without it, alloc_gnt=0, then the next cycle grants 45.
- Drop rst_n mid-stream after 10 grants and 3 releases:
  - outputs return to reset values asynchronously;
  - the next grant is 32.
